// File: rtl/bias_add_2.sv
// Bias add: loads KERN signed bias coefficients, then adds them channel-interleaved to accumulator
// values, arithmetic-shifts, saturates and streams results out. Define BIAS_ADD_RELU_EN to clamp negatives to 0.
module bias_add_2 #(
  parameter int KERN    = 16,
  parameter int N_PIX   = 64,
  parameter int COEFF_W = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic signed [COEFF_W-1:0] bias_V_dout,
  input  logic                      bias_V_empty_n,
  output logic                      bias_V_read,
  input  logic signed [ACC_W-1:0]   acc_V_dout,
  input  logic                      acc_V_empty_n,
  output logic                      acc_V_read,
  output logic signed [OUT_W-1:0]   output_V_din,
  input  logic                      output_V_full_n,
  output logic                      output_V_write
);

  localparam int LD_W  = (KERN > 1) ? $clog2(KERN) : 1;
  localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [LD_W-1:0]  LAST_CH  = LD_W'(KERN - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIX - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t                    state, state_next;
  logic [LD_W-1:0]           ld_cnt, ch_cnt;
  logic [PIX_W-1:0]          pix_cnt;
  logic signed [COEFF_W-1:0] bank [KERN];
  logic                      out_valid;
  logic signed [OUT_W-1:0]   out_data;

  logic                      bias_pop, acc_pop, last_coeff, last_acc;
  logic signed [COEFF_W-1:0] bias_sel;
  logic signed [ACC_W:0]     sum, shifted;
  logic signed [OUT_W-1:0]   sat_val, result;

  // Reads are gated by ap_rst_n so nothing pops while reset is held.
  always_comb begin
    bias_pop   = ap_rst_n && (state == LOAD) && bias_V_empty_n;
    acc_pop    = ap_rst_n && (state == RUN) && acc_V_empty_n && (!out_valid || output_V_full_n);
    last_coeff = (ld_cnt == LAST_CH);
    last_acc   = (ch_cnt == LAST_CH) && (pix_cnt == LAST_PIX);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (bias_pop && last_coeff) state_next = RUN;
      RUN:     if (acc_pop && last_acc)    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= LOAD;
    else           state <= state_next;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ld_cnt  <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
    end else if (bias_pop) begin
      if (last_coeff) begin
        ld_cnt  <= '0;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else begin
        ld_cnt <= ld_cnt + LD_W'(1);
      end
    end else if (acc_pop) begin
      if (ch_cnt == LAST_CH) begin
        ch_cnt  <= '0;
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PIX_W'(1);
      end else begin
        ch_cnt <= ch_cnt + LD_W'(1);
      end
    end
  end

  // NOTE: the bank is reset explicitly so a restarted load never sees stale coefficients;
  // a reset memory cannot map to RAM, which is acceptable for a per-channel register bank.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < KERN; i++) bank[i] <= '0;
    end else if (bias_pop) begin
      bank[ld_cnt] <= bias_V_dout;
    end
  end

  // The add is one bit wider than the accumulator so it can never wrap before saturation.
  always_comb begin
    bias_sel = bank[ch_cnt];
    sum      = {acc_V_dout[ACC_W-1], acc_V_dout}
             + {{(ACC_W + 1 - COEFF_W){bias_sel[COEFF_W-1]}}, bias_sel};
    shifted  = sum >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = OUT_MAX;
    else if (shifted < SAT_MIN) sat_val = OUT_MIN;
    else                        sat_val = shifted[OUT_W-1:0];
`ifdef BIAS_ADD_RELU_EN
    result = sat_val[OUT_W-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
  end

  // A pop always reloads the register, so a transfer and a pop in one cycle leave no bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (acc_pop) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_valid && output_V_full_n) begin
      out_valid <= 1'b0;
    end
  end

  assign bias_V_read    = bias_pop;
  assign acc_V_read     = acc_pop;
  assign output_V_write = out_valid;
  assign output_V_din   = out_data;

endmodule

// File: tb/tb_bias_add_2.sv
// Bench for bias_add_2: two instances (SHIFT=0 and SHIFT=8) share stimulus from queue-modelled FIFOs;
// a scoreboard compares every output transfer against expected values queued with the stimulus.
module tb_bias_add_2;
  localparam int KERN = 4, N_PIX = 2, COEFF_W = 16, ACC_W = 32, OUT_W = 16;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic [COEFF_W-1:0] bias_V_dout = '0;
  logic bias_V_empty_n = 1'b0, bias_V_read, bias_V_read8;
  logic [ACC_W-1:0] acc_V_dout = '0;
  logic acc_V_empty_n = 1'b0, acc_V_read, acc_V_read8;
  logic [OUT_W-1:0] din0, din8;
  logic output_V_full_n = 1'b1, write0, write8;

  always #5 ap_clk = ~ap_clk;

  bias_add_2 #(.KERN(KERN), .N_PIX(N_PIX), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
    .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read),
    .output_V_din(din0), .output_V_full_n(output_V_full_n), .output_V_write(write0));

  bias_add_2 #(.KERN(KERN), .N_PIX(N_PIX), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(8)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read8),
    .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read8),
    .output_V_din(din8), .output_V_full_n(output_V_full_n), .output_V_write(write8));

  typedef struct {
    int bias [4];
    int acc  [8];
    int exp0 [8];
    int exp8 [8];
  } frame_t;

  frame_t frames [3];

  int total = 0, bad = 0;
  logic [COEFF_W-1:0] bias_q [$];
  logic [ACC_W-1:0]   acc_q [$];
  int exp0_q [$], exp8_q [$], pop_cyc [$];
  bit bias_en = 1, acc_en = 1, full_en = 1, rand_mode = 0;
  int n_bias_pops = 0, n_acc_pops = 0, cyc = 0, bias_since_rst = 0;
  bit first_acc_pending = 1, prev_stall = 0;
  logic [OUT_W-1:0] prev_din = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef BIAS_ADD_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model(input longint acc, input longint bias, input int sh);
    longint s;
    s = (acc + bias) >>> sh;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return relu(int'(s));
  endfunction

  // FIFO models and scoreboard: drive on the falling edge, sample just before the rising edge.
  initial forever begin
    @(negedge ap_clk);
    cyc++;
    bias_V_empty_n  = bias_en && (bias_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    bias_V_dout     = (bias_q.size() > 0) ? bias_q[0] : '0;
    acc_V_empty_n   = acc_en && (acc_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    acc_V_dout      = (acc_q.size() > 0) ? acc_q[0] : '0;
    output_V_full_n = full_en && (!rand_mode || $urandom_range(0, 2) != 0);
    #4;
    if (!ap_rst_n) begin
      prev_stall = 0;
      bias_since_rst = 0;
      first_acc_pending = 1;
    end else begin
      if (prev_stall) begin
        check("hold_din", din0, prev_din);
        check("hold_write", write0, 1);
      end
      if (bias_V_read || acc_V_read || write0) begin
        check("load_run_excl", bias_V_read & acc_V_read, 0);
        check("dut8_handshake", {bias_V_read8, acc_V_read8, write8}, {bias_V_read, acc_V_read, write0});
      end
      if (write0 && !output_V_full_n) check("stall_acc_read", acc_V_read, 0);
      if (bias_V_read) begin
        void'(bias_q.pop_front());
        n_bias_pops++;
        bias_since_rst++;
      end
      if (acc_V_read) begin
        if (first_acc_pending) begin
          check("acc_after_load", bias_since_rst >= KERN, 1);
          first_acc_pending = 0;
        end
        void'(acc_q.pop_front());
        n_acc_pops++;
        pop_cyc.push_back(cyc);
      end
      if (write0 && output_V_full_n) begin
        check("out_avail", exp0_q.size() > 0, 1);
        if (exp0_q.size() > 0) begin
          check("out_shift0", $signed(din0), exp0_q.pop_front());
          check("out_shift8", $signed(din8), exp8_q.pop_front());
        end
      end
      prev_stall = write0 && !output_V_full_n;
      prev_din = din0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic push_frame(input frame_t f);
    for (int i = 0; i < 4; i++) bias_q.push_back(16'(f.bias[i]));
    for (int i = 0; i < 8; i++) begin
      acc_q.push_back(32'(f.acc[i]));
      exp0_q.push_back(relu(f.exp0[i]));
      exp8_q.push_back(relu(f.exp8[i]));
    end
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while ((exp0_q.size() > 0 || acc_q.size() > 0 || bias_q.size() > 0) && b < 2000) begin
      tick(1);
      b++;
    end
    check(name, b < 2000, 1);
    check({name, "_write_idle"}, write0, 0);
  endtask

  task automatic wait_pops(input bit acc_side, input int target);
    int b = 0;
    while (((acc_side ? n_acc_pops : n_bias_pops) < target) && b < 2000) begin
      tick(1);
      b++;
    end
    check("pop_wait", b < 2000, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_bias_read"}, bias_V_read, 0);
    check({tag, "_acc_read"}, acc_V_read, 0);
    check({tag, "_write"}, write0 | write8, 0);
    check({tag, "_din0"}, din0, 0);
    check({tag, "_din8"}, din8, 0);
  endtask

  task automatic flush();
    bias_q.delete(); acc_q.delete(); exp0_q.delete(); exp8_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b4 [4];
    logic [ACC_W-1:0] a;
    logic [COEFF_W-1:0] rb [4];

    frames[0] = '{'{1, 2, 3, 4}, '{10, 20, 30, 40, 50, 60, 70, 80},
                  '{11, 22, 33, 44, 51, 62, 73, 84}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    frames[1] = '{'{0, 256, 0, 0}, '{40000, 4096, -40000, -256, -1, 32767, -32768, 32'sh7fffffff},
                  '{32767, 4352, -32768, -256, -1, 32767, -32768, 32767},
                  '{156, 17, -157, -1, -1, 128, -128, 32767}};
    frames[2] = '{'{-5, 32767, -32768, 7}, '{0, 0, 0, 0, 5, 32'sh7fffffff, 32'sh80000000, 100},
                  '{-5, 32767, -32768, 7, 0, 32767, -32768, 107},
                  '{-1, 127, -128, 0, 0, 32767, -32768, 0}};

    // Power-on reset with data waiting in both FIFOs.
    bias_q.push_back(16'h5);
    acc_q.push_back(32'h7);
    tick(3);
    reset_checks("por");
    flush();
    ap_rst_n = 1'b1;

    // Table frames: exact outputs, one pop per cycle, return to LOAD between frames.
    for (int f = 0; f < 3; f++) begin
      pop_cyc.delete();
      push_frame(frames[f]);
      wait_idle($sformatf("drain_f%0d", f));
      check("acc_pops_per_frame", pop_cyc.size(), 8);
      check("burst_span", (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);
    end

    // Accumulators present in LOAD must wait for the 4th coefficient.
    b4 = '{9, -9, 100, -100};
    for (int i = 0; i < 3; i++) bias_q.push_back(16'(b4[i]));
    for (int i = 0; i < 8; i++) begin
      acc_q.push_back(32'(i * 1000 - 3000));
      exp0_q.push_back(model(i * 1000 - 3000, b4[i % 4], 0));
      exp8_q.push_back(model(i * 1000 - 3000, b4[i % 4], 8));
    end
    base = n_acc_pops;
    tick(6);
    check("acc_held_in_load", n_acc_pops - base, 0);
    check("partial_bias_popped", bias_q.size(), 0);
    bias_q.push_back(16'(b4[3]));
    wait_idle("drain_late_bias");

    // Downstream stall of 5 cycles mid-frame.
    push_frame(frames[0]);
    wait_pops(1, n_acc_pops + 7);
    full_en = 0;
    tick(1);
    base = n_acc_pops;
    tick(4);
    check("no_pop_during_stall", n_acc_pops - base, 0);
    check("write_during_stall", write0, 1);
    full_en = 1;
    wait_idle("drain_stall");

    // Random data with random FIFO bubbles and backpressure.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        rb[i] = 16'($urandom);
        bias_q.push_back(rb[i]);
      end
      for (int i = 0; i < 8; i++) begin
        a = $urandom;
        acc_q.push_back(a);
        exp0_q.push_back(model(longint'($signed(a)), longint'($signed(rb[i % 4])), 0));
        exp8_q.push_back(model(longint'($signed(a)), longint'($signed(rb[i % 4])), 8));
      end
      rand_mode = 1;
      wait_idle($sformatf("drain_rand%0d", f));
      rand_mode = 0;
    end

    // Reset after 2 coefficient pops: the partial load must be discarded.
    push_frame(frames[0]);
    wait_pops(0, n_bias_pops + 2);
    ap_rst_n = 1'b0;
    #1;
    reset_checks("rst_load");
    flush();
    push_frame(frames[1]);
    tick(2);
    check("rst_load_hold_bias_read", bias_V_read, 0);
    ap_rst_n = 1'b1;
    wait_idle("drain_after_rst_load");

    // Reset after 3 accumulator pops with a result pending.
    push_frame(frames[0]);
    wait_pops(1, n_acc_pops + 3);
    check("pending_before_rst", write0, 1);
    ap_rst_n = 1'b0;
    #1;
    reset_checks("rst_run");
    flush();
    push_frame(frames[2]);
    tick(2);
    check("rst_run_hold_acc_read", acc_V_read, 0);
    ap_rst_n = 1'b1;
    wait_idle("drain_after_rst_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bias_add_2.md
BIAS_ADD_2 -- requirements
Module: bias_add_2

Interface
REQ-001 SHALL have parameter KERN, default 16: output channels; bias coefficients per frame.
REQ-002 SHALL have parameter N_PIX, default 64: accumulator values per channel per frame.
REQ-003 SHALL have parameter COEFF_W, default 16: bias coefficient width, signed.
REQ-004 SHALL have parameter ACC_W, default 32: accumulator width, signed.
REQ-005 SHALL have parameter OUT_W, default 16: output width, signed.
REQ-006 SHALL have parameter SHIFT, default 8: arithmetic right shift applied after the bias add.
REQ-007 SHALL have port ap_clk, input, 1: single clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port bias_V_dout, input, COEFF_W: bias FIFO read data.
REQ-010 SHALL have port bias_V_empty_n, input, 1: bias FIFO holds data.
REQ-011 SHALL have port bias_V_read, output, 1: bias FIFO pop.
REQ-012 SHALL have port acc_V_dout, input, ACC_W: accumulator FIFO read data, channel-interleaved (ch0..chKERN-1, repeated).
REQ-013 SHALL have port acc_V_empty_n, input, 1: accumulator FIFO holds data.
REQ-014 SHALL have port acc_V_read, output, 1: accumulator FIFO pop.
REQ-015 SHALL have port output_V_din, output, OUT_W: result data.
REQ-016 SHALL have port output_V_full_n, input, 1: downstream FIFO has space.
REQ-017 SHALL have port output_V_write, output, 1: result push.

Function
REQ-018 SHALL implement a two-state FSM, LOAD and RUN, and hold a KERN x COEFF_W bias bank.
REQ-019 In LOAD, SHALL drive bias_V_read = bias_V_empty_n, write bias_V_dout to bank[ld_cnt] on each pop, and increment ld_cnt.
REQ-020 On the pop with ld_cnt == KERN-1, SHALL clear ld_cnt, ch_cnt and pix_cnt and enter RUN on the next cycle.
REQ-021 In LOAD, SHALL hold acc_V_read = 0; in RUN, SHALL hold bias_V_read = 0.
REQ-022 In RUN, SHALL drive acc_V_read = acc_V_empty_n & (!out_valid | output_V_full_n).
REQ-023 On each accepted value, SHALL compute sum = sext(acc_V_dout) + sext(bank[ch_cnt]) at ACC_W+1 bits, arithmetic-shift sum right by SHIFT, and saturate the result to OUT_W signed.
REQ-024 SHALL register the result into output_V_din and set out_valid; latency is 1 cycle from pop to output_V_write.
REQ-025 SHALL drive output_V_write = out_valid; a transfer occurs when output_V_write & output_V_full_n.
REQ-026 SHALL hold output_V_din stable while output_V_write & !output_V_full_n.
REQ-027 On a transfer with no new pop in the same cycle, SHALL clear out_valid; a simultaneous transfer and pop SHALL reload the register with no bubble.
REQ-028 On a pop, SHALL advance ch_cnt with wrap at KERN-1; pix_cnt SHALL advance on each ch_cnt wrap.
REQ-029 On the pop with ch_cnt == KERN-1 and pix_cnt == N_PIX-1, SHALL return to LOAD; a pending out_valid SHALL still drain in LOAD.
REQ-030 Throughput SHALL be one result per cycle in RUN with both FIFOs non-blocking.

Reset
REQ-031 On ap_rst_n low, SHALL immediately force state LOAD, all counters 0, out_valid 0, output_V_din 0 and bank entries 0.
REQ-032 While reset is asserted, bias_V_read, acc_V_read and output_V_write SHALL be 0.
REQ-033 Reset mid-frame SHALL discard any partial load or frame; after release, the block SHALL restart in LOAD awaiting KERN new coefficients.

Configuration
REQ-034 With BIAS_ADD_RELU_EN defined, SHALL force negative saturated results to 0, giving an output range of 0..2^(OUT_W-1)-1.
REQ-035 Without BIAS_ADD_RELU_EN, SHALL pass signed saturated results unchanged, giving an output range of -2^(OUT_W-1)..2^(OUT_W-1)-1.

Verification (KERN=4, N_PIX=2, SHIFT=0, OUT_W=16 unless stated)
REQ-036 Load biases 1,2,3,4, then feed accumulators 10,20,30,40,50,60,70,80 -> outputs 11,22,33,44,51,62,73,84 in order; FSM returns to LOAD after the 8th pop.
REQ-037 Accumulator 40000 plus bias 0 -> output 32767; accumulator -40000 -> -32768 without BIAS_ADD_RELU_EN, and 0 with it.
REQ-038 SHIFT=8: accumulator 0x1000 plus bias 0x100 -> output 0x11; accumulator -256 plus bias 0 -> output -1.
REQ-039 Hold output_V_full_n low for 5 cycles mid-frame -> output_V_din stable, acc_V_read 0 while out_valid; no loss or duplication after release.
REQ-040 Assert ap_rst_n low after 2 bias pops or after 3 accumulator pops -> all outputs 0 asynchronously; the next frame after release must reload 4 biases before the first acc_V_read.
REQ-041 Present accumulator data during LOAD with bias_V_empty_n low -> acc_V_read stays 0 until the 4th bias pop.
